// File: rtl/synch_bin_down_count.sv
// rtl/synch_bin_down_count.sv - loadable synchronous binary down counter / interval timer
// Counts a loaded value down to zero on enabled cycles, pulses tc, then stops or reloads.
module synch_bin_down_count #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             auto_reload,
  output logic [NBITS-1:0] counter,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] counter_q, counter_d;
  logic [NBITS-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    if (load) begin
      reload_d  = load_val;
      counter_d = load_val;
      // A zero load is an immediate terminal count, independent of auto_reload.
      if (load_val == '0) begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ena) begin
            if (counter_q > NBITS'(1)) begin
              counter_d = counter_q - NBITS'(1);
            end else if (counter_q == NBITS'(1)) begin
              counter_d = '0;
              tc_d      = 1'b1;
              state_d   = auto_reload ? ST_RUN : ST_DONE;
            end else begin
              // Sitting at zero in RUN only happens on the auto-reload path.
              counter_d = reload_q;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign counter = counter_q;
  assign tc      = tc_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule
